// File: rtl/dma_pkg.sv
// Shared types and constants for the memory-to-memory copy/fill engine.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dma_state_t;

    localparam int         WORD_BYTES     = 4;
    localparam logic [3:0] STRB_ALL       = 4'hF;
    localparam int         ADDR_W_DEFAULT = 32;
    localparam int         LEN_W_DEFAULT  = 16;

endpackage

// File: rtl/dma_copy_master.sv
// Copy/fill bus initiator: single-entry buffer between a combinational read
// port and an edge-committed write port, one word per cycle under grant.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; alignment and zero-length checks here
// RUN   | reads and writes issued while bus_gnt is high
// DONE  | one-cycle completion pulse, then back to IDLE
module dma_copy_master
    import dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int LEN_W  = LEN_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fill,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    input  logic [31:0]       pattern,
    input  logic              abort,
    input  logic              bus_gnt,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(WORD_BYTES);
    localparam logic [LEN_W-1:0]  CNT_ONE  = LEN_W'(1);

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [LEN_W-1:0]  rcnt, wcnt;
    logic              fill_q;
    logic [31:0]       pattern_q;
    logic [31:0]       data_buf;
    logic              buf_valid;
    logic              err_q;

    logic              load;
    logic              err_d;
    logic              rd_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        err_d    = 1'b0;
        rd_fire  = 1'b0;
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // In fill mode the source is never read, so its alignment is irrelevant.
                    if (dst_addr[1:0] != 2'b00 || (!fill && src_addr[1:0] != 2'b00)) begin
                        err_d = 1'b1;
                    end else if (len_words == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                rd_req   = (rcnt != '0) && !fill_q;
                rd_fire  = bus_gnt && (rcnt != '0) && !abort;
                wr_valid = bus_gnt && buf_valid && !abort;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wr_valid && wcnt == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            rcnt      <= '0;
            wcnt      <= '0;
            fill_q    <= 1'b0;
            pattern_q <= '0;
            data_buf  <= '0;
            buf_valid <= 1'b0;
        end else if (load) begin
            rd_ptr    <= src_addr;
            wr_ptr    <= dst_addr;
            rcnt      <= len_words;
            wcnt      <= len_words;
            fill_q    <= fill;
            pattern_q <= pattern;
            buf_valid <= 1'b0;
        end else begin
            if (rd_fire) begin
                data_buf <= fill_q ? pattern_q : rd_data;
                rd_ptr   <= rd_ptr + PTR_STEP;
                rcnt     <= rcnt - CNT_ONE;
            end
            if (wr_valid) begin
                wr_ptr <= wr_ptr + PTR_STEP;
                wcnt   <= wcnt - CNT_ONE;
            end
            // A refill on the same edge as a write keeps the buffer occupied.
            if (state_q == ST_RUN && abort) begin
                buf_valid <= 1'b0;
            end else if (rd_fire) begin
                buf_valid <= 1'b1;
            end else if (wr_valid) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign rd_addr = rd_ptr;
    assign wr_addr = wr_ptr;
    assign wr_data = data_buf;
    assign wr_strb = wr_valid ? STRB_ALL : 4'h0;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;

endmodule

// File: tb/tb_dma_copy_master.sv
// Directed bench for dma_copy_master against a small word RAM at 0x1000..0x10FC.
module tb_dma_copy_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, fill, abort, bus_gnt;
    logic [31:0] src_addr, dst_addr, pattern;
    logic [15:0] len_words;
    logic        rd_req, wr_valid, busy, done, err;
    logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
    logic [3:0]  wr_strb;

    logic [31:0] mem [64];

    int n_tests = 0;
    int n_fail  = 0;

    logic        lg_rd_req   [21];
    logic        lg_wr_valid [21];
    logic        lg_busy     [21];
    logic [31:0] lg_rd_addr  [21];
    logic [31:0] lg_wr_addr  [21];
    logic [31:0] lg_wr_data  [21];
    logic [3:0]  lg_strb     [21];
    int done_cyc, done_cnt, wr_cnt, err_cnt, rd_req_cnt, busy_cnt;

    always #5 clk = ~clk;

    dma_copy_master #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .fill(fill),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .pattern(pattern), .abort(abort), .bus_gnt(bus_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .busy(busy), .done(done), .err(err)
    );

    function automatic logic [5:0] idx(input logic [31:0] a);
        logic [31:0] t;
        t = (a - 32'h1000) >> 2;
        return t[5:0];
    endfunction

    assign rd_data = mem[idx(rd_addr)];

    always @(posedge clk) begin
        if (wr_valid) mem[idx(wr_addr)] <= wr_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one start and log outputs at mid-cycle for RUN cycles 1..ncyc.
    task automatic run_xfer(input logic f, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input logic [31:0] p,
                            input logic [20:0] gnt_low, input int abort_cyc, input int ncyc);
        done_cyc = 0; done_cnt = 0; wr_cnt = 0; err_cnt = 0; rd_req_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 21; i++) begin
            lg_rd_req[i] = 1'b0; lg_wr_valid[i] = 1'b0; lg_busy[i] = 1'b0;
            lg_rd_addr[i] = '0; lg_wr_addr[i] = '0; lg_wr_data[i] = '0; lg_strb[i] = '0;
        end
        @(negedge clk);
        start = 1'b1; fill = f; src_addr = s; dst_addr = d; len_words = n; pattern = p;
        bus_gnt = 1'b1; abort = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start   = 1'b0;
            bus_gnt = !gnt_low[k];
            abort   = (k == abort_cyc);
            #1;
            lg_rd_req[k] = rd_req; lg_wr_valid[k] = wr_valid; lg_busy[k] = busy;
            lg_rd_addr[k] = rd_addr; lg_wr_addr[k] = wr_addr;
            lg_wr_data[k] = wr_data; lg_strb[k] = wr_strb;
            if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = k; end
            if (wr_valid) wr_cnt++;
            if (err) err_cnt++;
            if (rd_req) rd_req_cnt++;
            if (busy) busy_cnt++;
        end
        abort = 1'b0; bus_gnt = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + 32'(i);
        rst = 1'b1; start = 1'b0; fill = 1'b0; abort = 1'b0; bus_gnt = 1'b0;
        src_addr = '0; dst_addr = '0; len_words = '0; pattern = '0;

        @(negedge clk); #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rd_req", 32'(rd_req), 0);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_wr_strb", 32'(wr_strb), 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_data", wr_data, 0);
        @(negedge clk); rst = 1'b0;

        // Plain copy, four words, continuous grant.
        run_xfer(1'b0, 32'h1000, 32'h1040, 16'd4, 32'h0, '0, 0, 8);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("cp_rd_req%0d", k), 32'(lg_rd_req[k]), 1);
            check($sformatf("cp_rd_addr%0d", k), lg_rd_addr[k], 32'h1000 + 32'(4*(k-1)));
        end
        check("cp_rd_req5", 32'(lg_rd_req[5]), 0);
        check("cp_wr_valid1", 32'(lg_wr_valid[1]), 0);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("cp_wr_valid%0d", k), 32'(lg_wr_valid[k]), 1);
            check($sformatf("cp_wr_addr%0d", k), lg_wr_addr[k], 32'h1040 + 32'(4*(k-2)));
            check($sformatf("cp_wr_data%0d", k), lg_wr_data[k], 32'hA500_0000 + 32'(k-2));
            check($sformatf("cp_wr_strb%0d", k), 32'(lg_strb[k]), 32'hF);
        end
        check("cp_done_cyc", 32'(done_cyc), 6);
        check("cp_done_cnt", 32'(done_cnt), 1);
        check("cp_wr_cnt", 32'(wr_cnt), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("cp_mem%0d", 16+i), mem[16+i], 32'hA500_0000 + 32'(i));

        // Fill, three words.
        run_xfer(1'b1, 32'h1000, 32'h1080, 16'd3, 32'hDEAD_BEEF, '0, 0, 7);
        check("fl_rd_req_cnt", 32'(rd_req_cnt), 0);
        for (int k = 2; k <= 4; k++) begin
            check($sformatf("fl_wr_addr%0d", k), lg_wr_addr[k], 32'h1080 + 32'(4*(k-2)));
            check($sformatf("fl_wr_data%0d", k), lg_wr_data[k], 32'hDEAD_BEEF);
            check($sformatf("fl_wr_strb%0d", k), 32'(lg_strb[k]), 32'hF);
        end
        check("fl_wr_cnt", 32'(wr_cnt), 3);
        check("fl_done_cyc", 32'(done_cyc), 5);
        check("fl_done_cnt", 32'(done_cnt), 1);
        check("fl_mem34", mem[34], 32'hDEAD_BEEF);

        // Copy with grant dropped in cycles 3 and 4.
        run_xfer(1'b0, 32'h1000, 32'h10C0, 16'd4, 32'h0, 21'b0_0000_0000_0000_0001_1000, 0, 10);
        check("gl_wr_valid3", 32'(lg_wr_valid[3]), 0);
        check("gl_wr_valid4", 32'(lg_wr_valid[4]), 0);
        check("gl_rd_req3", 32'(lg_rd_req[3]), 1);
        check("gl_rd_addr4", lg_rd_addr[4], 32'h1008);
        check("gl_wr_addr5", lg_wr_addr[5], 32'h10C4);
        check("gl_wr_data5", lg_wr_data[5], 32'hA500_0001);
        check("gl_wr_addr7", lg_wr_addr[7], 32'h10CC);
        check("gl_wr_cnt", 32'(wr_cnt), 4);
        check("gl_done_cyc", 32'(done_cyc), 8);
        for (int i = 0; i < 4; i++)
            check($sformatf("gl_mem%0d", 48+i), mem[48+i], 32'hA500_0000 + 32'(i));

        // Zero length.
        run_xfer(1'b0, 32'h1000, 32'h1040, 16'd0, 32'h0, '0, 0, 4);
        check("z_done_cyc", 32'(done_cyc), 1);
        check("z_wr_cnt", 32'(wr_cnt), 0);
        check("z_rd_req_cnt", 32'(rd_req_cnt), 0);

        // Misaligned source in copy mode.
        run_xfer(1'b0, 32'h1002, 32'h1040, 16'd2, 32'h0, '0, 0, 4);
        check("ma_err_cyc1", 32'(err_cnt), 1);
        check("ma_busy_cnt", 32'(busy_cnt), 0);
        check("ma_done_cnt", 32'(done_cnt), 0);
        check("ma_wr_cnt", 32'(wr_cnt), 0);

        // Misaligned source is ignored in fill mode.
        run_xfer(1'b1, 32'h1002, 32'h1090, 16'd1, 32'h1234_5678, '0, 0, 5);
        check("fma_err_cnt", 32'(err_cnt), 0);
        check("fma_done_cyc", 32'(done_cyc), 3);
        check("fma_mem36", mem[36], 32'h1234_5678);

        // Abort in RUN cycle 3 of an eight-word copy.
        run_xfer(1'b0, 32'h1000, 32'h10A0, 16'd8, 32'h0, '0, 3, 12);
        check("ab_wr_valid3", 32'(lg_wr_valid[3]), 0);
        check("ab_busy4", 32'(lg_busy[4]), 0);
        check("ab_wr_cnt", 32'(wr_cnt), 1);
        check("ab_done_cnt", 32'(done_cnt), 0);
        check("ab_mem41", mem[41], 32'hA500_0029);

        // Asynchronous reset in the middle of a transfer.
        run_xfer(1'b0, 32'h1000, 32'h10E0, 16'd8, 32'h0, '0, 0, 3);
        rst = 1'b1; #1;
        check("ar_busy", 32'(busy), 0);
        check("ar_rd_req", 32'(rd_req), 0);
        check("ar_wr_valid", 32'(wr_valid), 0);
        check("ar_rd_addr", rd_addr, 0);
        check("ar_wr_data", wr_data, 0);
        @(negedge clk); rst = 1'b0;
        run_xfer(1'b0, 32'h1010, 32'h10F0, 16'd2, 32'h0, '0, 0, 6);
        check("ar2_done_cyc", 32'(done_cyc), 4);
        check("ar2_wr_cnt", 32'(wr_cnt), 2);
        check("ar2_mem60", mem[60], 32'hA500_0004);
        check("ar2_mem61", mem[61], 32'hA500_0005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
